// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//    Round-robin arbiter that lets NREQ byte sources share one UART
//    transmitter at packet granularity. Once a requester wins, it keeps the
//    transmitter until it presents a byte flagged as end of packet.
//
// Parameters
//    WL       data word width in bits
//    NREQ     number of requesters (2, 4 or 8)
//    TIMEOUT  idle-owner release limit in CLK cycles (2..65535)
//
// Ports
//    CLK        system clock, rising edge
//    RST        asynchronous active-low reset
//    req        per-requester byte request, held until ack
//    last       per-requester end-of-packet flag for the presented byte
//    din        requester bytes, requester i at [i*WL +: WL]
//    tx_busy    shared transmitter busy
//    ack        one-cycle accept pulse, one bit per requester
//    tx_start   one-cycle start pulse to the transmitter
//    tx_data    byte to transmit, stable until the next tx_start
//    owner      index of the current packet owner
//    owner_vld  high while a packet is owned
//    abort      one-cycle pulse on timeout release
//
// Build option
//    ARB_TIMEOUT_EN  when defined, an owner that stops requesting in SEND
//                    is released after TIMEOUT cycles with an abort pulse.
//                    When undefined, abort is constant 0 and an owner keeps
//                    the transmitter until its last byte.

module uart_tx_arbiter #(
   parameter int unsigned WL      = 8,
   parameter int unsigned NREQ    = 4,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ-1:0]           last,
   input  logic [NREQ*WL-1:0]        din,
   input  logic                      tx_busy,
   output logic [NREQ-1:0]           ack,
   output logic                      tx_start,
   output logic [WL-1:0]             tx_data,
   output logic [$clog2(NREQ)-1:0]   owner,
   output logic                      owner_vld,
   output logic                      abort
);

   localparam int unsigned OW = $clog2(NREQ);

   // Parameter legality, checked at elaboration.
   if (!(NREQ == 2 || NREQ == 4 || NREQ == 8)) begin : g_bad_nreq
      $error("uart_tx_arbiter: NREQ must be 2, 4 or 8");
   end
   if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("uart_tx_arbiter: TIMEOUT must be in 2..65535");
   end

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      HOLD,
      WAIT
   } state_t;

   state_t          state;
   logic [OW-1:0]   last_owner;
   logic            end_flag;
   logic [OW-1:0]   next_owner;
   logic [OW-1:0]   cand;
   logic            found;

`ifdef ARB_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
   logic [15:0]     idle_cnt;
`endif

   // Round-robin pick: first active request after last_owner, wrapping.
   // NREQ is a power of two, so OW-bit addition wraps modulo NREQ; the
   // final iteration lands back on last_owner itself.
   always_comb begin
      next_owner = last_owner;
      cand       = '0;
      found      = 1'b0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         cand = last_owner + OW'(i);
         if (!found && req[cand]) begin
            next_owner = cand;
            found      = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= IDLE;
         ack        <= '0;
         tx_start   <= 1'b0;
         tx_data    <= '0;
         owner      <= '0;
         owner_vld  <= 1'b0;
         abort      <= 1'b0;
         end_flag   <= 1'b0;
         last_owner <= OW'(NREQ - 1);
`ifdef ARB_TIMEOUT_EN
         idle_cnt   <= '0;
`endif
      end else begin
         // Pulse outputs default low every cycle.
         ack      <= '0;
         tx_start <= 1'b0;
         abort    <= 1'b0;

         case (state)
            IDLE: begin
               if (|req) begin
                  owner     <= next_owner;
                  owner_vld <= 1'b1;
                  state     <= SEND;
               end
            end

            SEND: begin
               if (req[owner] && !tx_busy) begin
                  tx_start   <= 1'b1;
                  ack[owner] <= 1'b1;
                  tx_data    <= din[owner*WL +: WL];
                  end_flag   <= last[owner];
                  state      <= HOLD;
`ifdef ARB_TIMEOUT_EN
                  idle_cnt   <= '0;
`endif
               end
`ifdef ARB_TIMEOUT_EN
               else if (!req[owner]) begin
                  if (idle_cnt == TO_LAST) begin
                     abort      <= 1'b1;
                     last_owner <= owner;
                     owner_vld  <= 1'b0;
                     idle_cnt   <= '0;
                     state      <= IDLE;
                  end else begin
                     idle_cnt <= idle_cnt + 16'd1;
                  end
               end
`endif
            end

            // One dead cycle so the transmitter can raise tx_busy before
            // WAIT samples it.
            HOLD: state <= WAIT;

            WAIT: begin
               if (!tx_busy) begin
                  if (end_flag) begin
                     last_owner <= owner;
                     owner_vld  <= 1'b0;
                     state      <= IDLE;
                  end else begin
                     state <= SEND;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

   localparam int NREQ = 4;
   localparam int WL   = 8;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic [3:0]    req = '0;
   logic [3:0]    last = '0;
   logic [31:0]   din = '0;
   logic          tx_busy = 1'b0;
   logic [3:0]    ack;
   logic          tx_start;
   logic [7:0]    tx_data;
   logic [1:0]    owner;
   logic          owner_vld;
   logic          abort;

   always #5 CLK = ~CLK;

   uart_tx_arbiter #(.WL(WL), .NREQ(NREQ), .TIMEOUT(16)) dut (
      .CLK(CLK), .RST(RST), .req(req), .last(last), .din(din),
      .tx_busy(tx_busy), .ack(ack), .tx_start(tx_start), .tx_data(tx_data),
      .owner(owner), .owner_vld(owner_vld), .abort(abort)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Transaction-level reference: per-requester byte queues, round-robin
   // by packet, served in whole packets.
   logic [7:0] qd [4][$];
   bit         ql [4][$];
   int         grants[$];
   int         m_last;
   bit         m_active;
   int         m_owner;

   task automatic push_packet(input int id, input int len);
      for (int b = 0; b < len; b++) begin
         qd[id].push_back(8'($urandom));
         ql[id].push_back(b == len - 1);
      end
   endtask

   task automatic drive_from_queues();
      for (int i = 0; i < 4; i++) begin
         if (qd[i].size() > 0) begin
            req[i]         = 1'b1;
            din[i*8 +: 8]  = qd[i][0];
            last[i]        = ql[i][0];
         end else begin
            req[i]         = 1'b0;
            din[i*8 +: 8]  = 8'h00;
            last[i]        = 1'b0;
         end
      end
   endtask

   function automatic int rr_pick();
      for (int k = 1; k <= 4; k++) begin
         int i;
         i = (m_last + k) % 4;
         if (qd[i].size() > 0) return i;
      end
      return -1;
   endfunction

   task automatic do_reset();
      RST = 1'b0; req = '0; last = '0; din = '0; tx_busy = 1'b0;
      tick();
      tick();
      check("reset_outputs", {ack, tx_start, tx_data, owner, owner_vld, abort}, 0);
      RST = 1'b1;
      m_last = 3;
      m_active = 1'b0;
      grants.delete();
   endtask

   // busy_fixed = 0 selects a random transmitter busy time per byte.
   task automatic run_traffic(input int busy_fixed, input int budget);
      int busy_cnt = 0;
      bit prev_start = 1'b0;
      bit done = 1'b0;
      int cyc = 0;
      m_active = 1'b0;
      while (!done && cyc < budget) begin
         drive_from_queues();
         tx_busy = (busy_cnt > 0);
         tick();
         cyc++;
         if (busy_cnt > 0) busy_cnt--;
         check("ack_with_start", (ack != 0), tx_start);
         check("abort_quiet", abort, 0);
         if (tx_start) begin
            check("start_spacing", prev_start, 0);
            if (!m_active) begin
               m_owner = rr_pick();
               m_active = 1'b1;
            end
            if (m_owner < 0) begin
               check("spurious_start", 1, 0);
               m_active = 1'b0;
            end else begin
               check("owner", owner, m_owner);
               check("ack_bit", ack, 1 << m_owner);
               check("tx_data", tx_data, qd[m_owner][0]);
               check("owner_vld", owner_vld, 1);
               grants.push_back(m_owner);
               if (ql[m_owner][0]) begin
                  m_active = 1'b0;
                  m_last = m_owner;
               end
               void'(qd[m_owner].pop_front());
               void'(ql[m_owner].pop_front());
            end
            busy_cnt = (busy_fixed > 0) ? busy_fixed : int'($urandom_range(1, 12));
         end
         prev_start = tx_start;
         done = (qd[0].size() == 0) && (qd[1].size() == 0) && (qd[2].size() == 0) &&
                (qd[3].size() == 0) && !owner_vld && !m_active;
      end
      check("traffic_drained", done, 1);
      req = '0; last = '0; tx_busy = 1'b0;
   endtask

   typedef struct {
      logic [3:0] req;
      logic [3:0] lst;
      logic [7:0] d0;
      logic       busy;
      logic       exp_start;
      logic [3:0] exp_ack;
      logic [7:0] exp_data;
      logic [1:0] exp_owner;
      logic       exp_vld;
   } vec_t;

   vec_t tbl [5];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      int exp_order[$];
      int starts;
      int nbytes;

      // Single-byte packet from requester 0 straight after reset.
      tbl[0] = '{4'b0001, 4'b0001, 8'hA5, 1'b0, 1'b0, 4'b0000, 8'h00, 2'd0, 1'b1};
      tbl[1] = '{4'b0001, 4'b0001, 8'hA5, 1'b0, 1'b1, 4'b0001, 8'hA5, 2'd0, 1'b1};
      tbl[2] = '{4'b0000, 4'b0000, 8'hA5, 1'b1, 1'b0, 4'b0000, 8'hA5, 2'd0, 1'b1};
      tbl[3] = '{4'b0000, 4'b0000, 8'hA5, 1'b0, 1'b0, 4'b0000, 8'hA5, 2'd0, 1'b0};
      tbl[4] = '{4'b0000, 4'b0000, 8'hA5, 1'b0, 1'b0, 4'b0000, 8'hA5, 2'd0, 1'b0};

      do_reset();
      for (int r = 0; r < 5; r++) begin
         req = tbl[r].req; last = tbl[r].lst; din = {24'h0, tbl[r].d0}; tx_busy = tbl[r].busy;
         tick();
         check($sformatf("vec%0d", r), {tx_start, ack, tx_data, owner, owner_vld},
               {tbl[r].exp_start, tbl[r].exp_ack, tbl[r].exp_data, tbl[r].exp_owner, tbl[r].exp_vld});
      end

      // All four request together, busy 10 cycles: order 0,1,2,3,0.
      do_reset();
      push_packet(0, 1); push_packet(1, 1); push_packet(2, 1); push_packet(3, 1); push_packet(0, 1);
      run_traffic(10, 2000);
      exp_order = '{0, 1, 2, 3, 0};
      check("rr_count", grants.size(), exp_order.size());
      for (int i = 0; i < exp_order.size() && i < grants.size(); i++)
         check($sformatf("rr_order%0d", i), grants[i], exp_order[i]);

      // Requester 2's 3-byte packet is not interrupted by requester 1.
      do_reset();
      push_packet(1, 1); push_packet(2, 3); push_packet(1, 1);
      run_traffic(3, 2000);
      exp_order = '{1, 2, 2, 2, 1};
      check("pkt_count", grants.size(), exp_order.size());
      for (int i = 0; i < exp_order.size() && i < grants.size(); i++)
         check($sformatf("pkt_order%0d", i), grants[i], exp_order[i]);

      // tx_busy held high in SEND for 50 cycles.
      do_reset();
      tx_busy = 1'b1; req = 4'b0001; last = 4'b0001; din = 32'h0000003C;
      starts = 0;
      for (int c = 0; c < 50; c++) begin
         tick();
         if (tx_start || ack != 0) starts++;
      end
      check("busy_block", starts, 0);
      check("busy_block_vld", owner_vld, 1);
      tx_busy = 1'b0;
      tick();
      check("busy_release", {tx_start, ack, tx_data}, {1'b1, 4'b0001, 8'h3C});
      req = '0; last = '0; tx_busy = 1'b1;
      tick();
      tx_busy = 1'b0;
      tick();
      check("busy_done_vld", owner_vld, 0);

      // Reset during HOLD of requester 3's packet.
      do_reset();
      req = 4'b1000; last = 4'b1000; din = 32'h77000000;
      tick();
      check("hold_grant", {owner_vld, owner}, {1'b1, 2'd3});
      tick();
      check("hold_start", {tx_start, ack}, {1'b1, 4'b1000});
      RST = 1'b0;
      #1;
      check("rst_async", {ack, tx_start, tx_data, owner, owner_vld, abort}, 0);
      req = 4'b1001; last = 4'b1001; din = 32'h77000011;
      tick();
      tick();
      RST = 1'b1;
      tick();
      check("post_rst_owner", {owner_vld, owner}, {1'b1, 2'd0});
      tick();
      check("post_rst_start", {tx_start, ack, tx_data}, {1'b1, 4'b0001, 8'h11});

`ifdef ARB_TIMEOUT_EN
      // Owner 0 stops after byte 1 without last: release after 16 idle
      // SEND cycles (plus HOLD and WAIT after the start pulse).
      begin
         int edges;
         bit seen;
         do_reset();
         req = 4'b0011; last = 4'b0010; din = 32'h00002211;
         tick();
         tick();
         check("to_first_start", {tx_start, ack}, {1'b1, 4'b0001});
         req = 4'b0010; tx_busy = 1'b1;
         tick();
         tx_busy = 1'b0;
         edges = 1;
         seen = 1'b0;
         for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            edges++;
            if (abort) begin
               seen = 1'b1;
               check("to_vld_drop", owner_vld, 0);
            end
         end
         check("to_seen", seen, 1);
         check("to_latency", edges, 18);
         tick();
         check("to_single_pulse", abort, 0);
         check("to_next_owner", {owner_vld, owner}, {1'b1, 2'd1});
         tick();
         check("to_next_start", {tx_start, ack, tx_data}, {1'b1, 4'b0010, 8'h22});
      end
`else
      // Without the timeout, an idle owner keeps SEND and others wait.
      begin
         int aborts;
         do_reset();
         req = 4'b0001; last = 4'b0000; din = 32'h00000055;
         tick();
         tick();
         check("nto_first_start", {tx_start, ack}, {1'b1, 4'b0001});
         req = 4'b0010; last = 4'b0010; tx_busy = 1'b1;
         tick();
         tx_busy = 1'b0;
         aborts = 0;
         starts = 0;
         for (int c = 0; c < 40; c++) begin
            tick();
            if (abort) aborts++;
            if (tx_start) starts++;
         end
         check("nto_no_abort", aborts, 0);
         check("nto_no_start", starts, 0);
         check("nto_owner_held", {owner_vld, owner}, {1'b1, 2'd0});
      end
`endif

      // Randomized packet traffic against the queue model.
      for (int round = 0; round < 3; round++) begin
         do_reset();
         nbytes = 0;
         for (int i = 0; i < 4; i++) begin
            int npk;
            npk = int'($urandom_range(0, 3));
            for (int p = 0; p < npk; p++) begin
               int len;
               len = int'($urandom_range(1, 3));
               push_packet(i, len);
               nbytes += len;
            end
         end
         run_traffic(0, 20000);
         check($sformatf("rand%0d_bytes", round), grants.size(), nbytes);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
